disp_bcd_mux: RTL

- Output stage downstream of the GCD datapath. Takes the 8-bit result (0..255) on a load pulse and converts it to BCD with a sequential shift-add-3 engine.
- Drives a 4-digit, common-anode, multiplexed 7-segment display through `sal`/`an`.
- Replaces the purely combinational decode in the top level and leaves the previous value displayed while a conversion runs.

---
 rtl/disp_pkg.sv | 19 +
 rtl/bin2bcd_seq.sv | 64 ++++++
 rtl/disp_bcd_mux.sv | 85 ++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared types and 7-segment patterns for the BCD display path.
`timescale 1ns/1ps
package disp_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;
  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // {g,f,e,d,c,b,a}, active-low, digits 0..9
  localparam logic [6:0] SEG_LUT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_of(input bcd_t d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_LUT[d];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-add-3 converter: 8-bit binary to 3 BCD nibbles in 8 shifts.
`timescale 1ns/1ps
module bin2bcd_seq
  import disp_pkg::*;
(
  input  logic        clk,
  input  logic        clr_n,
  input  logic [7:0]  din,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd
);
  state_t      r_state;
  logic [7:0]  r_bin;
  logic [11:0] r_bcd;
  logic [2:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [11:0] w_adj;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++)
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
  end

  // busy trails the state by one cycle so it spans the full 9-cycle window
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (r_state != IDLE);
      case (r_state)
        IDLE: if (start) begin
          r_bin   <= din;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= SHIFT;
        end
        SHIFT: begin
          {r_bcd, r_bin} <= {w_adj[10:0], r_bin, 1'b0};
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) r_state <= LOAD;
        end
        LOAD: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;
endmodule

// File: rtl/disp_bcd_mux.sv
// BCD conversion plus 4-digit multiplexed common-anode 7-segment driver.
// Define LEADING_ZERO_BLANK_EN to blank leading zeros in the tens/hundreds slots.
`timescale 1ns/1ps
module disp_bcd_mux
  import disp_pkg::*;
#(
  parameter int REFRESH_BITS = 18
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       busy,
  output logic [6:0] sal,
  output logic [3:0] an
);
  logic [11:0]             w_bcd;
  logic                    w_done;
  logic [1:0]              w_slot;
  logic [6:0]              w_sal;
  logic [3:0]              w_an;
  logic [REFRESH_BITS-1:0] r_scan;
  bcd_t                    r_hun, r_ten, r_uni;
  logic [6:0]              r_sal;
  logic [3:0]              r_an;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .clr_n (clr_n),
    .din   (din),
    .start (din_valid),
    .busy  (busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  assign w_slot = r_scan[REFRESH_BITS-1 -: 2];

  always_comb begin
    w_sal = SEG_BLANK;
    w_an  = 4'b1111;
    case (w_slot)
      2'd0: begin w_an = 4'b1110; w_sal = seg_of(r_uni); end
      2'd1: begin
        w_an  = 4'b1101;
        w_sal = seg_of(r_ten);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_hun == 4'd0 && r_ten == 4'd0) w_sal = SEG_BLANK;
`endif
      end
      2'd2: begin
        w_an  = 4'b1011;
        w_sal = seg_of(r_hun);
`ifdef LEADING_ZERO_BLANK_EN
        if (r_hun == 4'd0) w_sal = SEG_BLANK;
`endif
      end
      default: begin w_an = 4'b1111; w_sal = SEG_BLANK; end
    endcase
  end

  // display registers only move on done, so the old value stays up mid-conversion
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_scan <= '0;
      r_hun  <= '0;
      r_ten  <= '0;
      r_uni  <= '0;
      r_sal  <= SEG_BLANK;
      r_an   <= 4'b1111;
    end else begin
      r_scan <= r_scan + 1'b1;
      if (w_done) begin
        r_hun <= w_bcd[11:8];
        r_ten <= w_bcd[7:4];
        r_uni <= w_bcd[3:0];
      end
      r_sal <= w_sal;
      r_an  <= w_an;
    end
  end

  assign sal = r_sal;
  assign an  = r_an;
endmodule
